// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: program counter, next-PC select and the IF/ID register.
// PC values are word indices; the external incrementer supplies pc_out + 1.
module fetch_pc_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc_out,
    input  logic [WIDTH-1:0] pc_incr_in,
    input  logic [WIDTH-1:0] instr_in,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_npc,
    output logic             if_id_valid,
    output logic [31:0]      fetch_count
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_if_id_instr;
    logic [WIDTH-1:0] r_if_id_npc;
    logic             r_if_id_valid;
    logic [31:0]      r_fetch_count;

    // Redirect squashes IF/ID to a NOP bubble and wins over a simultaneous stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_if_id_instr <= '0;
            r_if_id_npc   <= '0;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= '0;
        end else if (redirect) begin
            r_pc          <= branch_target;
            r_if_id_instr <= '0;
            r_if_id_npc   <= '0;
            r_if_id_valid <= 1'b0;
        end else if (!stall) begin
            r_pc          <= pc_incr_in;
            r_if_id_instr <= instr_in;
            r_if_id_npc   <= pc_incr_in;
            r_if_id_valid <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign pc_out      = r_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_npc   = r_if_id_npc;
    assign if_id_valid = r_if_id_valid;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: vector table through a scoreboard queue, plus a PC-wrap sequence
// on a second instance reset to the top of the address space.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
        logic [31:0] count;
    } vec_t;

    // Instance A: RESET_PC = 0
    logic        rst = 1'b1, stall = 1'b0, redirect = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc_out, pc_incr_in, instr_in, if_id_instr, if_id_npc, fetch_count;
    logic        if_id_valid;

    assign pc_incr_in = pc_out + 32'd1;
    assign instr_in   = 32'h100 + pc_out;

    fetch_pc_unit #(.WIDTH(32), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .branch_target(branch_target), .pc_out(pc_out), .pc_incr_in(pc_incr_in),
        .instr_in(instr_in), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    // Instance B: RESET_PC = 2^32-1
    logic        rst_w = 1'b1, stall_w = 1'b0, redirect_w = 1'b0;
    logic [31:0] branch_target_w = '0;
    logic [31:0] pc_out_w, pc_incr_in_w, instr_in_w, if_id_instr_w, if_id_npc_w, fetch_count_w;
    logic        if_id_valid_w;

    assign pc_incr_in_w = pc_out_w + 32'd1;
    assign instr_in_w   = 32'h100 + pc_out_w;

    fetch_pc_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFF)) u_dut_wrap (
        .clk(clk), .rst(rst_w), .stall(stall_w), .redirect(redirect_w),
        .branch_target(branch_target_w), .pc_out(pc_out_w), .pc_incr_in(pc_incr_in_w),
        .instr_in(instr_in_w), .if_id_instr(if_id_instr_w), .if_id_npc(if_id_npc_w),
        .if_id_valid(if_id_valid_w), .fetch_count(fetch_count_w)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    vec_t vecs[$];
    vec_t sb[$];

    initial begin
        vec_t e;
        //                 rst   stl   rdr   target  pc     instr        npc    v     count
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'd0,  32'd0, 32'h0,       32'd0, 1'b0, 32'd0}); // reset
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'd0,  32'd0, 32'h0,       32'd0, 1'b0, 32'd0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'd0,  32'd1, 32'h100,     32'd1, 1'b1, 32'd1}); // sequential
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'd0,  32'd2, 32'h101,     32'd2, 1'b1, 32'd2});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'd0,  32'd3, 32'h102,     32'd3, 1'b1, 32'd3});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'd0,  32'd3, 32'h102,     32'd3, 1'b1, 32'd3}); // stall x2
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'd0,  32'd3, 32'h102,     32'd3, 1'b1, 32'd3});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'd0,  32'd4, 32'h103,     32'd4, 1'b1, 32'd4});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'd0,  32'd5, 32'h104,     32'd5, 1'b1, 32'd5});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 32'd64, 32'd64, 32'h0,      32'd0, 1'b0, 32'd5}); // redirect+stall
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'd0,  32'd65, 32'h140,    32'd65, 1'b1, 32'd6});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'd0,  32'd66, 32'h141,    32'd66, 1'b1, 32'd7});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'd10, 32'd10, 32'h0,      32'd0, 1'b0, 32'd7}); // redirect only
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'd0,  32'd10, 32'h0,      32'd0, 1'b0, 32'd7}); // stalled bubble
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'd0,  32'd11, 32'h10A,    32'd11, 1'b1, 32'd8});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b1, 32'd99, 32'd0, 32'h0,       32'd0, 1'b0, 32'd0}); // reset beats all
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'd0,  32'd1, 32'h100,     32'd1, 1'b1, 32'd1});

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            stall         = vecs[i].stall;
            redirect      = vecs[i].redirect;
            branch_target = vecs[i].target;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d.pc", i),    pc_out,             e.pc);
            chk($sformatf("v%0d.instr", i), if_id_instr,        e.instr);
            chk($sformatf("v%0d.npc", i),   if_id_npc,          e.npc);
            chk($sformatf("v%0d.valid", i), {31'd0, if_id_valid}, {31'd0, e.valid});
            chk($sformatf("v%0d.count", i), fetch_count,        e.count);
        end

        // Long stall: five frozen edges, then resume as if nothing happened.
        @(negedge clk);
        stall = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("long_stall.pc",    pc_out,      32'd1);
        chk("long_stall.count", fetch_count, 32'd1);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("after_stall.pc",    pc_out,      32'd2);
        chk("after_stall.instr", if_id_instr, 32'h101);
        chk("after_stall.count", fetch_count, 32'd2);

        // PC wrap on the second instance.
        @(negedge clk);
        rst_w = 1'b1;
        @(posedge clk);
        #1;
        chk("wrap_rst.pc",    pc_out_w,              32'hFFFF_FFFF);
        chk("wrap_rst.valid", {31'd0, if_id_valid_w}, 32'd0);
        @(negedge clk);
        rst_w = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap.pc",    pc_out_w,              32'd0);
        chk("wrap.npc",   if_id_npc_w,           32'd0);
        chk("wrap.valid", {31'd0, if_id_valid_w}, 32'd1);
        chk("wrap.instr", if_id_instr_w,         32'h0000_00FF);
        chk("wrap.count", fetch_count_w,         32'd1);
        @(posedge clk);
        #1;
        chk("wrap2.pc",  pc_out_w,    32'd1);
        chk("wrap2.npc", if_id_npc_w, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch front end of the MIPS pipeline. It drives the incrementer's `pcin` and consumes the incrementer's `pcout`. The block holds the program counter and selects the next PC (sequential, branch redirect, or hold on stall). It latches the fetched instruction and its next-PC into the IF/ID pipeline register. PC values are word indices: the incrementer adds 1, not 4.

## Interface
Parameters:
- `WIDTH`, 32, width of PC, next-PC and instruction words.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit request to hold PC and IF/ID.
- `redirect`  in  1  taken branch/jump resolved downstream; load `branch_target`.
- `branch_target`  in  WIDTH  redirect destination (word index).
- `pc_out`  out  WIDTH  current PC; drives incrementer `pcin` and instruction-memory address.
- `pc_incr_in`  in  WIDTH  incrementer `pcout` (expected `pc_out`+1).
- `instr_in`  in  WIDTH  instruction-memory read data for `pc_out` (combinational read).
- `if_id_instr`  out  WIDTH  latched instruction.
- `if_id_npc`  out  WIDTH  latched next-PC of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `fetch_count`  out  32  number of instructions loaded into IF/ID since reset.

## Operation
- State:
  - PC register.
  - IF/ID register (`if_id_instr`, `if_id_npc`, `if_id_valid`).
  - `fetch_count`.
- Priority per edge: `rst` > `redirect` > `stall` > normal.
- Reset (`rst`=1 at edge):
  - `pc_out`=RESET_PC.
  - `if_id_instr`=0, `if_id_npc`=0, `if_id_valid`=0.
  - `fetch_count`=0.
- Redirect:
  - `pc_out` <= `branch_target`.
  - IF/ID squashed: instr=0 (NOP), npc=0, valid=0.
  - `fetch_count` unchanged.
  - Redirect wins over a simultaneous `stall`.
- Stall (no redirect): PC, IF/ID and `fetch_count` all hold their values.
- Normal:
  - `pc_out` <= `pc_incr_in`.
  - `if_id_instr` <= `instr_in`.
  - `if_id_npc` <= `pc_incr_in`.
  - `if_id_valid` <= 1.
  - `fetch_count` += 1.
- Arithmetic:
  - The block performs no PC addition itself; `pc_incr_in` is used verbatim.
  - Wrap of PC from 2^WIDTH-1 to 0 is accepted without flagging.
  - `fetch_count` wraps modulo 2^32.
- No X propagation: every register has a defined reset value. `rst` asserted mid-stall or mid-redirect resets unconditionally.

## Timing
- `pc_out` is registered. The next PC is visible one cycle after the deciding edge.
- Fetch latency: the instruction at PC p appears on `if_id_instr` one edge after `pc_out`=p, provided that edge is unstalled and not redirected.
- Redirect penalty: one bubble.
  - Edge N (redirect) sets `pc_out`=target and valid=0.
  - Edge N+1 loads the target instruction with valid=1.
- Stall asserted for k cycles freezes all outputs for k edges. The next unstalled edge proceeds exactly as if the stall never occurred.
- Outputs change only on rising `clk`. Combinational paths:
  - `pc_out` to `pc_incr_in` (through the incrementer).
  - `pc_out` to `instr_in` (through instruction memory).
  - No combinational path from any input to any output.

## Test plan
- **Reset:** RESET_PC=0; hold `rst` 2 cycles, then release with incrementer attached. Required: `pc_out`=0, valid=0, count=0 during reset; then `pc_out` 1,2,3 on successive edges; `if_id_npc` 1,2,3; count 1,2,3.
- **Sequential fetch:** memory word i holds 0x100+i; run 4 cycles from reset. Required: `if_id_instr` 0x100,0x101,0x102,0x103 with valid=1.
- **Stall:** at `pc_out`=3 assert `stall` 2 cycles. Required: `pc_out` stays 3; IF/ID and count frozen; after release, next edge gives `pc_out`=4, `if_id_instr`=0x103.
- **Redirect with simultaneous stall:** at `pc_out`=5 assert `redirect`=1, `stall`=1, `branch_target`=64. Required: next `pc_out`=64, valid=0, instr=0; following edge gives `if_id_instr`=0x140, `if_id_npc`=65, valid=1.
- **Wrap:** RESET_PC=2^32-1, normal cycle. Required: `pc_out`=0, `if_id_npc`=0, valid=1.
- **Mid-operation reset:** assert `rst` while `stall`=1 and `redirect`=1. Required: `pc_out`=RESET_PC, IF/ID cleared, count=0 on that edge.
